// File: rtl/bp_fe_realigner.sv
// Fetch realigner: turns word-aligned fetch data into whole RVC/RV32 instructions.
// It also carries the low half of a 32-bit instruction that straddles two fetch words.
package bp_fe_realigner_pkg;
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int instr_width_gp = 32;

  function automatic int vaddr_width_of(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction
endpackage

module bp_fe_realigner
  import bp_fe_realigner_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int vaddr_width_p = vaddr_width_of(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic                      fetch_v_i,
  output logic                      fetch_ready_o,
  input  logic [vaddr_width_p-1:0]  fetch_pc_i,
  input  logic [instr_width_gp-1:0] fetch_data_i,
  output logic                      instr_v_o,
  input  logic                      instr_ready_i,
  output logic [instr_width_gp-1:0] instr_o,
  output logic [vaddr_width_p-1:0]  instr_pc_o,
  output logic                      instr_compressed_o
);

  logic [instr_width_gp-1:0] word_data;
  logic [vaddr_width_p-1:0]  word_base;
  logic                      word_v;
  logic                      word_p;
  logic [15:0]               leftover_data;
  logic [vaddr_width_p-1:0]  leftover_pc;
  logic                      leftover_v;

  logic [15:0] cur_half;
  logic        half_is_wide;
  logic        case_a, case_b, case_c, case_d;
  logic        instr_fire, consume, last_consumed, fetch_fire;
  logic [vaddr_width_p-1:0] half_pc;

  logic unused_pc_bit0;
  assign unused_pc_bit0 = fetch_pc_i[0];

  assign cur_half     = word_p ? word_data[31:16] : word_data[15:0];
  assign half_is_wide = (cur_half[1:0] == 2'b11);
  assign half_pc      = word_base + vaddr_width_p'({word_p, 1'b0});

  // Priority decode: a pending leftover always completes first.
  assign case_a = leftover_v;
  assign case_b = !leftover_v && !half_is_wide;
  assign case_c = !leftover_v && half_is_wide && !word_p;
  assign case_d = !leftover_v && half_is_wide && word_p;

  assign instr_v_o     = word_v && !flush_i && !case_d;
  assign instr_fire    = instr_v_o && instr_ready_i;
  // A straddling low half is parked in the leftover without waiting on the consumer.
  assign consume       = instr_fire || (word_v && case_d && !flush_i);
  assign last_consumed = consume && (word_p || case_c);
  assign fetch_ready_o = reset_n_i && !flush_i && (!word_v || last_consumed);
  assign fetch_fire    = fetch_v_i && fetch_ready_o;

  always_comb begin
    instr_o            = word_data;
    instr_pc_o         = word_base;
    instr_compressed_o = 1'b0;
    if (case_a) begin
      instr_o    = {cur_half, leftover_data};
      instr_pc_o = leftover_pc;
    end else if (case_b) begin
      instr_o            = {16'h0000, cur_half};
      instr_pc_o         = half_pc;
      instr_compressed_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      word_v     <= 1'b0;
      word_p     <= 1'b0;
      leftover_v <= 1'b0;
    end else if (flush_i) begin
      word_v     <= 1'b0;
      word_p     <= 1'b0;
      leftover_v <= 1'b0;
    end else begin
      if (consume && case_a) leftover_v <= 1'b0;
      if (consume && case_d) leftover_v <= 1'b1;
      if (fetch_fire) begin
        word_v <= 1'b1;
        word_p <= fetch_pc_i[1];
      end else if (consume) begin
        if (!word_p && !case_c) word_p <= 1'b1;
        else                    word_v <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; the valid bits above qualify them.
  always_ff @(posedge clk_i) begin
    if (fetch_fire) begin
      word_data <= fetch_data_i;
      word_base <= {fetch_pc_i[vaddr_width_p-1:2], 2'b00};
    end
    if (consume && case_d) begin
      leftover_data <= cur_half;
      leftover_pc   <= half_pc;
    end
  end

endmodule

// File: doc/bp_fe_realigner.md
BP_FE_REALIGNER -- requirements
Module: bp_fe_realigner

Interface
REQ-001 SHALL take parameter bp_params_p, default e_bp_default_cfg; it supplies vaddr_width_p (39 in the default config), and instr_width_gp is 32.
REQ-002 SHALL have clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have flush_i, input, 1 bit: discard all held fetch data (redirect).
REQ-005 SHALL have fetch_v_i, input, 1 bit: fetch word valid.
REQ-006 SHALL have fetch_ready_o, output, 1 bit: realigner can accept a fetch word.
REQ-007 SHALL have fetch_pc_i, input, vaddr_width_p bits: PC of the first useful halfword; bit[0] always 0; bit[1]=1 means only the upper halfword is useful.
REQ-008 SHALL have fetch_data_i, input, 32 bits: word-aligned fetch data.
REQ-009 SHALL have instr_v_o, output, 1 bit: assembled instruction valid toward the instruction scanner.
REQ-010 SHALL have instr_ready_i, input, 1 bit: consumer accepts the instruction.
REQ-011 SHALL have instr_o, output, 32 bits: the instruction, with upper 16 bits zero when compressed.
REQ-012 SHALL have instr_pc_o, output, vaddr_width_p bits: PC of the instruction's first halfword.
REQ-013 SHALL have instr_compressed_o, output, 1 bit: the instruction is 16-bit (low two bits not 2'b11).

Function
REQ-014 SHALL hold state as: word register (data, base PC, valid, halfword index p in {0,1}) and leftover register (16-bit data, PC, valid).
REQ-015 SHALL accept a fetch word on fetch_v_i & fetch_ready_o; the register loads data, base PC = {fetch_pc_i[hi:2], 2'b00}, and p = fetch_pc_i[1].
REQ-016 SHALL drive fetch_ready_o = !word_v | (the last halfword of the word is consumed this cycle) & !flush_i, so back-to-back words have no bubble.
REQ-017 SHALL take current halfword h = p ? data[31:16] : data[15:0] and evaluate, in priority order:
REQ-018 case A, leftover valid: instr_o = {h, leftover}, instr_pc_o = leftover PC, compressed = 0; on handshake, consume h and clear the leftover.
REQ-019 case B, h[1:0] != 2'b11: instr_o = {16'h0, h}, PC = base + 2*p, compressed = 1; on handshake, consume h.
REQ-020 case C, p == 0 and h is a 32-bit low half: instr_o = data, PC = base, compressed = 0; on handshake, consume both halfwords.
REQ-021 case D, p == 1 and h is a 32-bit low half: instr_v_o = 0; move h to the leftover with PC = base + 2; consume h unconditionally without waiting on instr_ready_i.
REQ-022 SHALL drive instr_v_o = word_v & !flush_i & !caseD; instr outputs are combinational from registered state, so latency is 1 cycle from fetch acceptance.
REQ-023 SHALL, when consuming a halfword with p == 0 (and not the whole word), set p = 1; any other consumption clears word_v.
REQ-024 SHALL, when instr_v_o & !instr_ready_i, hold all outputs stable; the state does not change.
REQ-025 SHALL, on flush_i, clear word_v and leftover_v next edge, drop any simultaneous fetch (fetch_ready_o = 0), and suppress instr_v_o.
REQ-026 SHALL keep a leftover across words whose PC is discontiguous; the upstream guarantees contiguity or issues a flush.

Reset
REQ-027 SHALL, on reset_n_i low, asynchronously clear word_v, leftover_v and p to 0; instr_v_o = 0, and fetch_ready_o = 0 while in reset.
REQ-028 SHALL, after reset release, drive fetch_ready_o = 1 in the first cycle; data and PC registers need no reset.

Verification
REQ-029 SHALL cover: word 32'h0000_0013 at PC 0x1000, ready = 1 -> next cycle instr 32'h0000_0013, PC 0x1000, compressed = 0, fetch_ready_o = 1.
REQ-030 SHALL cover: word 32'h4505_4501 at PC 0x2000 -> 16'h4501 at 0x2000, then 16'h4505 at 0x2002, both compressed, on consecutive cycles.
REQ-031 SHALL cover: word 32'h0513_4501 at PC 0x3000, then 32'h0000_0000 at 0x3004 -> 16'h4501 at 0x3000; the leftover captures 16'h0513; next output is 32'h0000_0513 at PC 0x3002.
REQ-032 SHALL cover: fetch PC 0x4002 with data 32'h4501_xxxx -> a single compressed 16'h4501 at 0x4002; the low halfword is ignored.
REQ-033 SHALL cover: instr_ready_i = 0 for 3 cycles while valid -> outputs held constant and fetch_ready_o = 0 throughout.
REQ-034 SHALL cover: flush_i with a leftover held and fetch_v_i = 1 -> leftover dropped, fetch not accepted, and the next word at 0x5000 decodes with no leftover merged.
